// File: rtl/verdict_pkg.sv
// ============================================================================
// Module      : verdict_pkg
// Description : Shared types and field layout for the verdict collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package verdict_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int HDR_TS_LSB = 0;

    // The aktv field sits directly above the timestamp in both header and record.
    function automatic int hdr_aktv_lsb(input int ts_w);
        return ts_w;
    endfunction

    // Record layout, LSB first: ts, aktv, then all output values.
    function automatic int rec_width(input int num_out, input int data_w, input int ts_w);
        return ts_w + num_out + num_out * data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Synchronous FIFO; push and pop may coincide even when full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int PEEK_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic [PEEK_W-1:0]      rd_data_nxt_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o        = (count_q == C_FULL);
    assign empty_o       = (count_q == '0);
    assign count_o       = count_q;
    assign do_push       = push_i & (~full_o | pop_i);
    assign do_pop        = pop_i & ~empty_o;
    assign rd_ptr_nxt    = rd_ptr_q + 1'b1;
    assign rd_data_o     = mem_q[rd_ptr_q];
    // Second-oldest entry lets a consumer chain records without an idle cycle.
    assign rd_data_nxt_o = mem_q[rd_ptr_nxt][PEEK_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_nxt;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/verdict_collector.sv
// ============================================================================
// Module      : verdict_collector
// Description : Captures active monitor outputs as timestamped records and
//               streams them as header + data words. Optional timestamp
//               counter enabled by VERDICT_COLLECTOR_TIMESTAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module verdict_collector
    import verdict_pkg::*;
#(
    parameter int NUM_OUT = 4,
    parameter int DATA_W  = 64,
    parameter int TS_W    = 32,
    parameter int DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_OUT*DATA_W-1:0] out_data,
    input  logic [NUM_OUT-1:0]        out_aktv,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic                      m_hdr,
    output logic                      m_last,
    output logic                      overflow,
    output logic [15:0]               drop_count
);

    localparam int HDR_W    = NUM_OUT + TS_W;
    localparam int AKTV_LSB = hdr_aktv_lsb(TS_W);
    localparam int REC_W    = rec_width(NUM_OUT, DATA_W, TS_W);
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    logic [TS_W-1:0]           ts_cur;
    logic [REC_W-1:0]          rec_in;
    logic [REC_W-1:0]          head;
    logic [HDR_W-1:0]          head_nxt;
    logic [NUM_OUT-1:0]        head_aktv;
    logic [NUM_OUT*DATA_W-1:0] head_data;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      cap;
    logic                      drop;
    logic                      handshake;
    logic                      has_next;

    state_t                    state_q;
    logic                      m_valid_q;
    logic [DATA_W-1:0]         m_data_q;
    logic                      m_hdr_q;
    logic                      m_last_q;
    logic [NUM_OUT-1:0]        rem_q;
    logic                      overflow_q;
    logic [15:0]               drop_q;

    logic [NUM_OUT-1:0]        src_mask;
    logic [NUM_OUT-1:0]        rem_nxt;
    logic [DATA_W-1:0]         sel_word;
    logic                      last_nxt;

`ifdef VERDICT_COLLECTOR_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q <= '0;
        end else if (en) begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign ts_cur = ts_q;
`else
    assign ts_cur = '0;
`endif

    function automatic logic [DATA_W-1:0] mk_hdr(input logic [HDR_W-1:0] r);
        logic [DATA_W-1:0] w;
        w = '0;
        w[HDR_TS_LSB +: TS_W]  = r[HDR_TS_LSB +: TS_W];
        w[AKTV_LSB +: NUM_OUT] = r[AKTV_LSB +: NUM_OUT];
        return w;
    endfunction

    assign cap       = en & (|out_aktv);
    assign rec_in    = {out_data, out_aktv, ts_cur};
    assign handshake = m_valid_q & m_ready;
    assign fifo_pop  = (state_q == ST_DATA) & handshake & m_last_q;
    assign fifo_push = cap & (~fifo_full | fifo_pop);
    assign drop      = cap & fifo_full & ~fifo_pop;
    assign has_next  = (fifo_count > CNT_W'(1));
    assign head_aktv = head[AKTV_LSB +: NUM_OUT];
    assign head_data = head[HDR_W +: NUM_OUT*DATA_W];

    sync_fifo #(
        .WIDTH  (REC_W),
        .DEPTH  (DEPTH),
        .PEEK_W (HDR_W)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push_i        (fifo_push),
        .wr_data_i     (rec_in),
        .pop_i         (fifo_pop),
        .rd_data_o     (head),
        .rd_data_nxt_o (head_nxt),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .count_o       (fifo_count)
    );

    // Next data word: lowest still-pending aktv bit of the record at the FIFO head.
    always_comb begin
        src_mask = (state_q == ST_HDR) ? head_aktv : rem_q;
        sel_word = '0;
        rem_nxt  = src_mask;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (src_mask[i]) begin
                sel_word = head_data[i*DATA_W +: DATA_W];
                rem_nxt  = src_mask & ~(NUM_OUT'(1) << i);
            end
        end
        last_nxt = (rem_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_hdr_q   <= 1'b0;
            m_last_q  <= 1'b0;
            rem_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        m_valid_q <= 1'b1;
                        m_hdr_q   <= 1'b1;
                        m_last_q  <= 1'b0;
                        m_data_q  <= mk_hdr(head[HDR_W-1:0]);
                        state_q   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (handshake) begin
                        m_hdr_q  <= 1'b0;
                        m_data_q <= sel_word;
                        m_last_q <= last_nxt;
                        rem_q    <= rem_nxt;
                        state_q  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (handshake) begin
                        if (m_last_q) begin
                            if (has_next) begin
                                m_hdr_q  <= 1'b1;
                                m_last_q <= 1'b0;
                                m_data_q <= mk_hdr(head_nxt);
                                state_q  <= ST_HDR;
                            end else begin
                                m_valid_q <= 1'b0;
                                m_hdr_q   <= 1'b0;
                                m_last_q  <= 1'b0;
                                m_data_q  <= '0;
                                state_q   <= ST_IDLE;
                            end
                        end else begin
                            m_data_q <= sel_word;
                            m_last_q <= last_nxt;
                            rem_q    <= rem_nxt;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_hdr      = m_hdr_q;
    assign m_last     = m_last_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_verdict_collector.sv
// ============================================================================
// Module      : tb_verdict_collector
// Description : Self-checking bench for verdict_collector with a record-level
//               reference model; honours VERDICT_COLLECTOR_TIMESTAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_verdict_collector;

    localparam int NUM_OUT = 4;
    localparam int DATA_W  = 64;
    localparam int TS_W    = 32;
    localparam int DEPTH   = 8;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      en = 1'b0;
    logic [NUM_OUT*DATA_W-1:0] out_data = '0;
    logic [NUM_OUT-1:0]        out_aktv = '0;
    logic                      m_ready = 1'b0;
    logic                      m_valid;
    logic [DATA_W-1:0]         m_data;
    logic                      m_hdr;
    logic                      m_last;
    logic                      overflow;
    logic [15:0]               drop_count;

    verdict_collector #(
        .NUM_OUT (NUM_OUT),
        .DATA_W  (DATA_W),
        .TS_W    (TS_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .out_data   (out_data),
        .out_aktv   (out_aktv),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_hdr      (m_hdr),
        .m_last     (m_last),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hdr;
        logic        last;
        logic [63:0] data;
    } word_t;

    word_t       exp_q[$];
    int          occ_m;
    logic [15:0] drops_m;
    logic        ovf_m;
    logic [31:0] ts_m;
    bit          prev_stall;
    int          n_checks;
    int          n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hdr_ts(input logic [31:0] t);
`ifdef VERDICT_COLLECTOR_TIMESTAMP_EN
        return t;
`else
        return 32'd0 & t;
`endif
    endfunction

    task automatic clear_model();
        exp_q.delete();
        occ_m      = 0;
        drops_m    = '0;
        ovf_m      = 1'b0;
        ts_m       = '0;
        prev_stall = 1'b0;
    endtask

    task automatic push_rec(input logic [3:0] a, input logic [255:0] d, input logic [31:0] t);
        word_t w;
        int    hi;
        hi = 0;
        for (int i = 0; i < NUM_OUT; i++) if (a[i]) hi = i;
        w.hdr = 1'b1; w.last = 1'b0; w.data = '0;
        w.data[31:0]  = hdr_ts(t);
        w.data[35:32] = a;
        exp_q.push_back(w);
        for (int i = 0; i < NUM_OUT; i++) begin
            if (a[i]) begin
                w.hdr = 1'b0; w.last = (i == hi); w.data = d[i*64 +: 64];
                exp_q.push_back(w);
            end
        end
        occ_m++;
    endtask

    // Runs just before each rising edge: checks what the DUT shows, then applies
    // the edge's effect (transfer, capture/drop, timestamp) to the model.
    task automatic model_eval();
        bit    popped;
        word_t w;
        popped = 1'b0;
        if (rst) begin
            clear_model();
            return;
        end
        chk("drop_count", {48'd0, drop_count}, {48'd0, drops_m});
        chk("overflow", {63'd0, overflow}, {63'd0, ovf_m});
        if (prev_stall) chk("valid_held", {63'd0, m_valid}, 64'd1);
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", {63'd0, m_valid}, 64'd0);
            end else begin
                w = exp_q[0];
                chk("m_data", m_data, w.data);
                chk("m_hdr", {63'd0, m_hdr}, {63'd0, w.hdr});
                chk("m_last", {63'd0, m_last}, {63'd0, w.last});
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    if (w.last) begin
                        occ_m--;
                        popped = 1'b1;
                    end
                end
            end
        end
        prev_stall = m_valid && !m_ready;
        if (en && (|out_aktv)) begin
            if (occ_m < DEPTH || popped) begin
                push_rec(out_aktv, out_data, ts_m);
            end else begin
                if (drops_m != 16'hFFFF) drops_m++;
                ovf_m = 1'b1;
            end
        end
        if (en) ts_m++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        en = 1'b0; out_aktv = '0; m_ready = 1'b1;
        while ((exp_q.size() != 0 || m_valid) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_data(input string tag);
        int n;
        n = 0;
        while (!(m_valid && !m_hdr) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk(tag, {63'd0, m_valid & ~m_hdr}, 64'd1);
    endtask

    task automatic rand_data();
        for (int i = 0; i < NUM_OUT; i++) out_data[i*64 +: 64] = {$urandom, $urandom};
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_model();

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_data", m_data, 64'd0);
        chk("rst_hdr", {63'd0, m_hdr}, 64'd0);
        chk("rst_last", {63'd0, m_last}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        chk("rst_drop", {48'd0, drop_count}, 64'd0);

        // Single event at ts=1000 with two-cycle latency
        en = 1'b1; out_aktv = '0;
        repeat (1000) tick();
        out_aktv = 4'b0001; out_data = '0; out_data[63:0] = 64'd1; m_ready = 1'b1;
        tick();
        en = 1'b0; out_aktv = '0;
        chk("lat_n1_valid", {63'd0, m_valid}, 64'd0);
        tick();
        chk("lat_n2_valid", {63'd0, m_valid}, 64'd1);
        chk("single_hdr", m_data, {28'd0, 4'b0001, hdr_ts(32'd1000)});
        chk("single_hdr_flag", {63'd0, m_hdr}, 64'd1);
        tick();
        chk("single_data", m_data, 64'd1);
        chk("single_last", {63'd0, m_last}, 64'd1);
        drain();

        // Two active outputs, signed values, ascending order
        en = 1'b1; out_aktv = 4'b1010; out_data = '0;
        out_data[1*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFB;
        out_data[3*64 +: 64] = 64'd7;
        m_ready = 1'b1;
        tick();
        en = 1'b0; out_aktv = '0;
        wait_data("multi_wait");
        chk("multi_w1", m_data, 64'hFFFF_FFFF_FFFF_FFFB);
        chk("multi_w1_last", {63'd0, m_last}, 64'd0);
        tick();
        chk("multi_w2", m_data, 64'd7);
        chk("multi_w2_last", {63'd0, m_last}, 64'd1);
        drain();

        // Backpressure in DATA
        en = 1'b1; out_aktv = 4'b1111;
        for (int i = 0; i < NUM_OUT; i++) out_data[i*64 +: 64] = 64'hA0 + 64'(i);
        m_ready = 1'b1;
        tick();
        en = 1'b0; out_aktv = '0;
        wait_data("bp_wait");
        m_ready = 1'b0;
        repeat (10) begin
            tick();
            chk("bp_data", m_data, 64'hA0);
            chk("bp_valid", {63'd0, m_valid}, 64'd1);
        end
        drain();

        // en gating freezes the timestamp
        en = 1'b1; out_aktv = 4'b0001; rand_data();
        tick();
        en = 1'b0; out_aktv = 4'b0011;
        repeat (5) begin rand_data(); tick(); end
        en = 1'b1; out_aktv = 4'b0100; rand_data();
        tick();
        drain();

        // Overflow: 10 records into an 8-deep FIFO with the sink stalled
        m_ready = 1'b0; en = 1'b1;
        repeat (10) begin
            out_aktv = 4'($urandom_range(1, 15));
            rand_data();
            tick();
        end
        en = 1'b0; out_aktv = '0;
        tick();
        chk("ovf_drop_count", {48'd0, drop_count}, 64'd2);
        chk("ovf_flag", {63'd0, overflow}, 64'd1);
        drain();

        // Reset in the middle of a record
        en = 1'b1; out_aktv = 4'b1111; rand_data(); m_ready = 1'b1;
        tick();
        en = 1'b0; out_aktv = '0;
        wait_data("rstmid_wait");
        m_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_valid", {63'd0, m_valid}, 64'd0);
        chk("rstmid_drop", {48'd0, drop_count}, 64'd0);
        chk("rstmid_ovf", {63'd0, overflow}, 64'd0);
        m_ready = 1'b1;
        repeat (3) tick();
        en = 1'b1; out_aktv = 4'b0001; out_data = '0; out_data[63:0] = 64'h55;
        tick();
        en = 1'b0; out_aktv = '0;
        tick();
        chk("rstmid_new_valid", {63'd0, m_valid}, 64'd1);
        chk("rstmid_new_hdr", m_data, {28'd0, 4'b0001, 32'd0});
        drain();

        // Randomized traffic, first lightly then heavily backpressured
        for (int c = 0; c < 3000; c++) begin
            en       = ($urandom_range(0, 9) < 8);
            out_aktv = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            rand_data();
            m_ready  = (c < 1500) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 2);
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/verdict_collector.md
Name: verdict_collector

Overview:
- Output-side counterpart to the stimulus driver that feeds input events into the monitor (topEntity).
- Watches the monitor's output values and their `_aktv` flags.
- On every cycle in which any output is active, captures a timestamped record into a FIFO.
- Streams records out as a word sequence over a valid/ready interface: one header word, then one word per active output. The sink is a trace dumper or host link.

Parameters:
- NUM_OUT, 4, number of monitor output streams (1..16)
- DATA_W, 64, width of each output value and of every stream word
- TS_W, 32, width of the cycle timestamp; NUM_OUT+TS_W <= DATA_W
- DEPTH, 8, FIFO depth in records; power of two, >= 2

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  monitor enable; gates capture and timestamp counting
- out_data  in  NUM_OUT*DATA_W  monitor output values; output_i is at slice [i*DATA_W +: DATA_W], signed
- out_aktv  in  NUM_OUT  per-output active flag, valid in the same cycle as out_data
- m_valid  out  1  stream word valid
- m_ready  in  1  sink accepts word
- m_data  out  DATA_W  stream word
- m_hdr  out  1  current word is a header
- m_last  out  1  current word is the last of its record
- overflow  out  1  sticky; set when a record is dropped
- drop_count  out  16  records dropped, saturating at 0xFFFF

Behaviour:
- Reset (rst=1 at a rising edge):
  - Outputs: m_valid=0, m_data=0, m_hdr=0, m_last=0, overflow=0, drop_count=0.
  - FIFO is emptied, timestamp=0, FSM enters IDLE.
  - Reset mid-record discards the partial record; nothing resumes after reset.
- Timestamp: increments by 1 each cycle with en=1 and wraps modulo 2^TS_W. It holds while en=0.
- Capture: a cycle with en=1 and |out_aktv=1 forms record {ts, out_aktv, out_data}.
  - The record is pushed at the closing edge if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the record is dropped: drop_count++ (saturating) and overflow=1.
  - en=0 or out_aktv=0: nothing is captured.
- FSM states IDLE, HDR, DATA.
  - IDLE: FIFO non-empty -> load head record into the output register, go to HDR. Latency: a record captured in cycle N gives m_valid=1 in cycle N+2, provided the FIFO was empty and the FSM idle.
  - HDR: m_data = {zeros, aktv[NUM_OUT-1:0], ts[TS_W-1:0]} with ts in the LSBs; m_hdr=1. On handshake, go to DATA.
  - DATA: emits out_data for each set aktv bit, ascending index. m_last=1 on the highest set bit. On the handshake with m_last=1, pop the FIFO and go to HDR if the FIFO still holds another record, else IDLE (back-to-back records, no bubble).
- Handshake: a transfer occurs when m_valid & m_ready. While m_valid=1 and m_ready=0, m_data, m_hdr and m_last stay stable. m_valid never drops without a transfer, except on reset.
- A record has 1+popcount(aktv) words; a header is never the last word.
- Simultaneous push and pop on a full FIFO: both happen, occupancy stays DEPTH, no drop.
- The serializer runs regardless of en.

Optional Feature:
- Macro VERDICT_COLLECTOR_TIMESTAMP_EN.
- Defined: timestamp counter present, behaviour as above.
- Undefined: no counter logic; the header ts field is 0; all other fields and timing are unchanged.

Decomposition:
- Shared package verdict_pkg holds:
  - the FSM state enum;
  - header field offsets/widths (HDR_TS_LSB=0, HDR_AKTV_LSB=TS_W);
  - the record struct-width helper.
- One sub-module, sync_fifo: parameterized width/depth, synchronous reset, push/pop/full/empty, same-cycle push+pop allowed when full.

Test Plan:
- Single event: out_aktv=4'b0001, output_0=1 at ts=1000 -> m_valid at capture+2 with hdr {aktv=1, ts=1000}, then data=1 with m_last=1.
- Multiple active: aktv=4'b1010, output_1=-5, output_3=7 -> header, then -5, then 7 (m_last=1), 3 words total.
- Backpressure: m_ready low for 10 cycles during DATA -> m_data held stable, no word lost or repeated.
- Overflow: DEPTH=8, m_ready=0, 10 consecutive active cycles -> 8 records retained, drop_count=2, overflow=1; releasing m_ready emits the 8 records in order.
- en gating: en=0 for 5 cycles with aktv=1 -> no capture, ts frozen; next capture's ts = previous+1 relative to enabled cycles.
- Reset mid-record: rst pulsed during DATA -> next cycle m_valid=0, FIFO empty, drop_count=0; a new event gives a fresh header with ts counted from 0.
